// File: rtl/uart_cmd_responder_if.sv
// uart_cmd_responder_if
//   Bundles the serial lines and the consumer/producer handshake of the
//   UART command responder so the block and its environment share one port.
//   Signals:
//     RX          serial command line from remote (idle high, 8N1, LSB first)
//     TX          serial response line to remote (idle high, 8N1, LSB first)
//     cmd         last complete command {high byte, low byte}
//     cmd_rdy     level, a complete command is held in cmd
//     clr_cmd_rdy one-cycle pulse from the consumer, clears cmd_rdy
//     resp        response byte, sampled when send_resp is accepted
//     send_resp   one-cycle request to transmit resp
//     resp_sent   level, last response fully shifted out incl. stop bit
//   Modports: slave = the responder block, master = its environment.
interface uart_cmd_responder_if;
  logic        RX;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;

  modport slave (
    input  RX, clr_cmd_rdy, resp, send_resp,
    output TX, cmd, cmd_rdy, resp_sent
  );

  modport master (
    output RX, clr_cmd_rdy, resp, send_resp,
    input  TX, cmd, cmd_rdy, resp_sent
  );
endinterface

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder
//   Receives two-byte commands over an 8N1 UART line (high byte first),
//   presents them on cmd/cmd_rdy, and transmits single response bytes on
//   an independent 8N1 TX line (full duplex).
//   Parameters:
//     BAUD_DIV  clk cycles per UART bit (16..65535)
//     TMO_BITS  bit times allowed between high and low byte (timeout build)
//   Ports:
//     clk       system clock, all state on rising edge
//     rst       asynchronous active-high reset
//     bus       uart_cmd_responder_if.slave (RX, TX, cmd, cmd_rdy,
//               clr_cmd_rdy, resp, send_resp, resp_sent)
//   Configuration macro:
//     CMD_TIMEOUT_EN  when defined, a pending high byte is dropped if no
//                     low-byte start bit arrives within TMO_BITS bit times.
module uart_cmd_responder #(
  parameter int unsigned BAUD_DIV = 5208,
  parameter int unsigned TMO_BITS = 40
) (
  input logic               clk,
  input logic               rst,
  uart_cmd_responder_if.slave bus
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_e;
  typedef enum logic       {ASM_WAIT_HI, ASM_WAIT_LO}             asmState_e;
  typedef enum logic       {TX_IDLE, TX_XMIT}                     txState_e;

  // Two-flop synchronizer; reset high so a reset never looks like a start bit.
  logic rxMeta_q, rxSync_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= bus.RX;
      rxSync_q <= rxMeta_q;
    end
  end

  // Receiver: detect start, confirm at half bit, then sample each bit midpoint.
  rxState_e    rxState_q, rxState_d;
  logic [15:0] rxBaud_q, rxBaud_d;
  logic [2:0]  rxBit_q, rxBit_d;
  logic [7:0]  rxShift_q, rxShift_d;
  logic        rxValid_q, rxValid_d;
  logic        rxFrameErr_q, rxFrameErr_d;
  logic        rxStartOk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxState_q    <= RX_IDLE;
      rxBaud_q     <= '0;
      rxBit_q      <= '0;
      rxShift_q    <= '0;
      rxValid_q    <= 1'b0;
      rxFrameErr_q <= 1'b0;
    end else begin
      rxState_q    <= rxState_d;
      rxBaud_q     <= rxBaud_d;
      rxBit_q      <= rxBit_d;
      rxShift_q    <= rxShift_d;
      rxValid_q    <= rxValid_d;
      rxFrameErr_q <= rxFrameErr_d;
    end
  end

  always_comb begin
    rxState_d    = rxState_q;
    rxBaud_d     = rxBaud_q;
    rxBit_d      = rxBit_q;
    rxShift_d    = rxShift_q;
    rxValid_d    = 1'b0;
    rxFrameErr_d = 1'b0;
    rxStartOk    = 1'b0;
    case (rxState_q)
      RX_IDLE: begin
        if (!rxSync_q) begin
          rxState_d = RX_START;
          rxBaud_d  = '0;
        end
      end
      RX_START: begin
        if (rxBaud_q == HALF_LAST) begin
          rxBaud_d = '0;
          if (rxSync_q) begin
            rxState_d = RX_IDLE;
          end else begin
            rxState_d = RX_DATA;
            rxBit_d   = '0;
            rxStartOk = 1'b1;
          end
        end else begin
          rxBaud_d = rxBaud_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (rxBaud_q == BAUD_LAST) begin
          rxBaud_d  = '0;
          rxShift_d = {rxSync_q, rxShift_q[7:1]};
          if (rxBit_q == 3'd7) begin
            rxState_d = RX_STOP;
          end else begin
            rxBit_d = rxBit_q + 3'd1;
          end
        end else begin
          rxBaud_d = rxBaud_q + 16'd1;
        end
      end
      RX_STOP: begin
        if (rxBaud_q == BAUD_LAST) begin
          rxBaud_d     = '0;
          rxState_d    = RX_IDLE;
          rxValid_d    = rxSync_q;
          rxFrameErr_d = !rxSync_q;
        end else begin
          rxBaud_d = rxBaud_q + 16'd1;
        end
      end
      default: rxState_d = RX_IDLE;
    endcase
  end

  // Optional inter-byte timeout; without the macro it is a constant zero.
  asmState_e asmState_q, asmState_d;
  logic      tmoExpired;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TMO_CYCLES = TMO_BITS * BAUD_DIV;
  localparam int unsigned TMO_W      = $clog2(TMO_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);

  logic [TMO_W-1:0] tmoCnt_q, tmoCnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmoCnt_q <= '0;
    else     tmoCnt_q <= tmoCnt_d;
  end

  // Counts only while waiting for the low byte with the receiver idle.
  always_comb begin
    tmoCnt_d   = tmoCnt_q;
    tmoExpired = 1'b0;
    if (asmState_q != ASM_WAIT_LO) begin
      tmoCnt_d = '0;
    end else if (rxState_q == RX_IDLE && !rxValid_q && !rxFrameErr_q) begin
      if (tmoCnt_q == TMO_LAST) tmoExpired = 1'b1;
      else                      tmoCnt_d   = tmoCnt_q + 1'b1;
    end
  end
`else
  assign tmoExpired = 1'b0;
`endif

  // Byte assembler: pairs bytes into a command, set of cmd_rdy beats clear.
  logic [7:0]  hiByte_q, hiByte_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmdRdy_q, cmdRdy_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asmState_q <= ASM_WAIT_HI;
      hiByte_q   <= '0;
      cmd_q      <= '0;
      cmdRdy_q   <= 1'b0;
    end else begin
      asmState_q <= asmState_d;
      hiByte_q   <= hiByte_d;
      cmd_q      <= cmd_d;
      cmdRdy_q   <= cmdRdy_d;
    end
  end

  always_comb begin
    asmState_d = asmState_q;
    hiByte_d   = hiByte_q;
    cmd_d      = cmd_q;
    cmdRdy_d   = cmdRdy_q;
    if (bus.clr_cmd_rdy) cmdRdy_d = 1'b0;
    if (rxStartOk && asmState_q == ASM_WAIT_HI) cmdRdy_d = 1'b0;
    if (rxFrameErr_q) begin
      asmState_d = ASM_WAIT_HI;
    end else if (rxValid_q) begin
      if (asmState_q == ASM_WAIT_HI) begin
        hiByte_d   = rxShift_q;
        asmState_d = ASM_WAIT_LO;
      end else begin
        cmd_d      = {hiByte_q, rxShift_q};
        cmdRdy_d   = 1'b1;
        asmState_d = ASM_WAIT_HI;
      end
    end else if (tmoExpired) begin
      asmState_d = ASM_WAIT_HI;
    end
  end

  // Transmitter: frame = {stop, data, start} shifted out LSB first.
  txState_e    txState_q, txState_d;
  logic [15:0] txBaud_q, txBaud_d;
  logic [3:0]  txBit_q, txBit_d;
  logic [9:0]  txFrame_q, txFrame_d;
  logic        respSent_q, respSent_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txState_q  <= TX_IDLE;
      txBaud_q   <= '0;
      txBit_q    <= '0;
      txFrame_q  <= '1;
      respSent_q <= 1'b0;
    end else begin
      txState_q  <= txState_d;
      txBaud_q   <= txBaud_d;
      txBit_q    <= txBit_d;
      txFrame_q  <= txFrame_d;
      respSent_q <= respSent_d;
    end
  end

  always_comb begin
    txState_d  = txState_q;
    txBaud_d   = txBaud_q;
    txBit_d    = txBit_q;
    txFrame_d  = txFrame_q;
    respSent_d = respSent_q;
    case (txState_q)
      TX_IDLE: begin
        if (bus.send_resp) begin
          txFrame_d  = {1'b1, bus.resp, 1'b0};
          txBaud_d   = '0;
          txBit_d    = '0;
          respSent_d = 1'b0;
          txState_d  = TX_XMIT;
        end
      end
      TX_XMIT: begin
        if (txBaud_q == BAUD_LAST) begin
          txBaud_d = '0;
          if (txBit_q == 4'd9) begin
            txState_d  = TX_IDLE;
            respSent_d = 1'b1;
          end else begin
            txFrame_d = {1'b1, txFrame_q[9:1]};
            txBit_d   = txBit_q + 4'd1;
          end
        end else begin
          txBaud_d = txBaud_q + 16'd1;
        end
      end
      default: txState_d = TX_IDLE;
    endcase
  end

  assign bus.TX        = (txState_q == TX_XMIT) ? txFrame_q[0] : 1'b1;
  assign bus.cmd       = cmd_q;
  assign bus.cmd_rdy   = cmdRdy_q;
  assign bus.resp_sent = respSent_q;

endmodule

// File: doc/uart_cmd_responder.md
UART_CMD_RESPONDER -- requirements
Module: uart_cmd_responder

Interface
REQ-001 Parameter BAUD_DIV, default 5208, clk cycles per UART bit (50 MHz / 9600 baud); legal range 16..65535.
REQ-002 Parameter TMO_BITS, default 40, bit times allowed between the high and low command bytes (CMD_TIMEOUT_EN only).
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 RX  input  1  serial command line from remote, idle high, 8N1, LSB first.
REQ-006 TX  output  1  serial response line to remote, idle high, 8N1, LSB first.
REQ-007 cmd  output  16  last complete command, {high byte, low byte}.
REQ-008 cmd_rdy  output  1  level; complete command held in cmd.
REQ-009 clr_cmd_rdy  input  1  one-cycle pulse from consumer; clears cmd_rdy.
REQ-010 resp  input  8  response byte, sampled when send_resp is accepted.
REQ-011 send_resp  input  1  one-cycle request to transmit resp.
REQ-012 resp_sent  output  1  level; last response fully shifted out, stop bit included.

Function
REQ-013 RX shall pass through a 2-flop synchronizer (both flops set high on reset) before any use.
REQ-014 Receiver FSM shall have states IDLE, START, DATA, STOP.
REQ-015 IDLE->START on synchronized RX low; START shall wait BAUD_DIV/2 cycles and return to IDLE (false start) if RX is high at that point, else go to DATA.
REQ-016 DATA shall sample 8 bits, one every BAUD_DIV cycles, at bit midpoints, shifting LSB first.
REQ-017 STOP shall sample once after BAUD_DIV cycles; RX high = byte valid, RX low = framing error, byte discarded; both return to IDLE.
REQ-018 Byte assembler shall have states WAIT_HI, WAIT_LO; first valid byte is the high byte, second the low byte.
REQ-019 On a valid low byte, cmd shall update and cmd_rdy shall set in the same cycle (1 clk after stop-bit sample).
REQ-020 cmd shall hold its value until the next complete command; cmd_rdy shall clear on clr_cmd_rdy or on the start bit of the next high byte.
REQ-021 clr_cmd_rdy in the same cycle cmd_rdy sets: set wins.
REQ-022 Framing error in either byte shall return the assembler to WAIT_HI; cmd and cmd_rdy unchanged.
REQ-023 Transmitter FSM shall have states IDLE, XMIT; send_resp in IDLE latches resp, clears resp_sent, enters XMIT next cycle.
REQ-024 XMIT shall drive start bit, 8 data bits LSB first, stop bit, each exactly BAUD_DIV cycles, then set resp_sent and return to IDLE.
REQ-025 send_resp during XMIT shall be ignored; resp_sent stays low until the current frame ends.
REQ-026 Receiver and transmitter shall run independently; full-duplex traffic shall not corrupt either direction.
REQ-027 Baud and bit counters shall be sized for BAUD_DIV and shall never wrap mid-frame.

Reset
REQ-028 On rst: TX=1, cmd=16'h0000, cmd_rdy=0, resp_sent=0, all FSMs in IDLE/WAIT_HI, counters zero.
REQ-029 rst asserted mid-frame shall abort both directions immediately; after release, reception restarts at the next falling edge of RX, and a half-received command is lost.

Configuration
REQ-030 Macro CMD_TIMEOUT_EN: when defined, WAIT_LO shall return to WAIT_HI if no low-byte start bit arrives within TMO_BITS*BAUD_DIV cycles after the high byte's stop sample; the high byte is discarded.
REQ-031 Without CMD_TIMEOUT_EN, WAIT_LO shall wait indefinitely and no timeout counter shall be synthesized.

Verification (BAUD_DIV=16 for simulation)
REQ-032 Send bytes 8'h20, 8'h00 on RX -> cmd=16'h2000, cmd_rdy=1 one clk after the second stop sample; pulse clr_cmd_rdy -> cmd_rdy=0, cmd held.
REQ-033 Pulse send_resp with resp=8'hA5 -> TX shows 0,1,0,1,0,0,1,0,1,1 at 16-cycle intervals; resp_sent=1 after 160 cycles; second send_resp mid-frame ignored.
REQ-034 Send 8'h43, then 8'hF1 with stop bit forced low -> cmd_rdy stays 0; then 8'h43, 8'hF1 -> cmd=16'h43F1.
REQ-035 Drive an 8-cycle low glitch on idle RX -> no byte accepted; following 8'h47, 8'hF1 -> cmd=16'h47F1.
REQ-036 Assert rst during the high byte's DATA phase -> all outputs at reset values; next full pair 8'h4B, 8'hF1 -> cmd=16'h4BF1.
REQ-037 With CMD_TIMEOUT_EN: 8'h40, idle 41 bit times, then 8'h00, 8'h01 -> cmd=16'h0001; without the macro the same stimulus -> cmd=16'h4000.
